// File: rtl/abro_state_machine.sv
// ABRO controller: waits for events A and B in any order or together, then raises O until reset (R).
// O is either a level for the whole DONE stay or a single-cycle pulse on entry, chosen by O_PULSE.
module abro_state_machine #(
   parameter bit O_PULSE = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       a,
   input  logic       b,
   output logic       o,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GOT_A = 2'b01,
      GOT_B = 2'b10,
      DONE  = 2'b11
   } state_e;

   state_e state_q, state_d;
   logic   pulse_q, pulse_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pulse_q <= pulse_d;
      end
   end

   // Each state remembers which events have already been seen; DONE is absorbing.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (a && b)      state_d = DONE;
            else if (a)      state_d = GOT_A;
            else if (b)      state_d = GOT_B;
            else             state_d = IDLE;
         end
         GOT_A:   if (b) state_d = DONE;
         GOT_B:   if (a) state_d = DONE;
         DONE:    state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // The pulse flop is set only on the edge that enters DONE, so it lasts exactly one cycle.
   always_comb begin
      pulse_d = (state_d == DONE) && (state_q != DONE);
   end

   assign o     = O_PULSE ? pulse_q : (state_q == DONE);
   assign state = state_q;

endmodule

// File: tb/tb_abro_state_machine.sv
// Scoreboard bench for abro_state_machine: one level-output and one pulse-output instance share the
// same stimulus; the driver queues hand-computed expectations and a monitor pops and compares them.
module tb_abro_state_machine;

   typedef struct {
      string      tag;
      logic [1:0] expState;
      logic       expLevel;
      logic       expPulse;
   } expect_t;

   logic       clk;
   logic       reset;
   logic       a;
   logic       b;
   logic       oLevel;
   logic       oPulse;
   logic [1:0] stateLevel;
   logic [1:0] statePulse;

   expect_t    expQueue[$];
   event       sampleEv;
   int         assertCount = 0;
   int         failCount   = 0;

   abro_state_machine #(.O_PULSE(1'b0)) dutLevel (
      .clk   (clk),
      .reset (reset),
      .a     (a),
      .b     (b),
      .o     (oLevel),
      .state (stateLevel)
   );

   abro_state_machine #(.O_PULSE(1'b1)) dutPulse (
      .clk   (clk),
      .reset (reset),
      .a     (a),
      .b     (b),
      .o     (oPulse),
      .state (statePulse)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [1:0] actual, input logic [1:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
      end
   endtask

   // Monitor: whenever the driver signals a sample point, drain and compare all queued expectations.
   initial begin
      forever begin
         @(sampleEv);
         while (expQueue.size() > 0) begin
            expect_t e;
            e = expQueue.pop_front();
            checkOutput({e.tag, " state(level)"}, stateLevel, e.expState);
            checkOutput({e.tag, " o(level)"},     {1'b0, oLevel}, {1'b0, e.expLevel});
            checkOutput({e.tag, " state(pulse)"}, statePulse, e.expState);
            checkOutput({e.tag, " o(pulse)"},     {1'b0, oPulse}, {1'b0, e.expPulse});
         end
      end
   end

   task automatic pushExpect(input string tag, input logic [1:0] st, input logic lv, input logic pl);
      expect_t e;
      e.tag      = tag;
      e.expState = st;
      e.expLevel = lv;
      e.expPulse = pl;
      expQueue.push_back(e);
      ->sampleEv;
   endtask

   // Drive a/b away from the active edge, then queue what both instances should show after it.
   task automatic applyStimulus(input string tag, input logic ia, input logic ib,
                                input logic [1:0] st, input logic lv, input logic pl);
      @(negedge clk);
      a = ia;
      b = ib;
      @(posedge clk);
      #1;
      pushExpect(tag, st, lv, pl);
   endtask

   // Asynchronous mid-cycle reset, a clock edge while held, then release with the given inputs.
   task automatic applyReset(input string tag, input logic ra, input logic rb,
                             input logic [1:0] st, input logic lv, input logic pl);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      pushExpect({tag, " async"}, 2'b00, 1'b0, 1'b0);
      a = 1'b1;
      b = 1'b1;
      @(posedge clk);
      #1;
      pushExpect({tag, " held"}, 2'b00, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      a     = ra;
      b     = rb;
      @(posedge clk);
      #1;
      pushExpect({tag, " release"}, st, lv, pl);
   endtask

   initial begin
      #20000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      failCount++;
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   initial begin
      reset = 1'b1;
      a     = 1'b1;
      b     = 1'b1;
      #2;
      pushExpect("por", 2'b00, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      pushExpect("por held", 2'b00, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      pushExpect("ab across release", 2'b11, 1'b1, 1'b1);
      applyStimulus("done idle1", 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);
      applyStimulus("done idle2", 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);

      applyReset("r-ab", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
      applyStimulus("ab together", 1'b1, 1'b1, 2'b11, 1'b1, 1'b1);
      applyStimulus("done b only", 1'b0, 1'b1, 2'b11, 1'b1, 1'b0);

      applyReset("r-a", 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
      applyStimulus("got_a hold1", 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
      applyStimulus("got_a hold2", 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
      applyStimulus("got_a a again", 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);

      applyReset("r-b", 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
      applyStimulus("got_b hold1", 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
      applyStimulus("got_b b again", 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
      applyStimulus("got_b then a", 1'b1, 1'b0, 2'b11, 1'b1, 1'b1);
      applyStimulus("got_b done", 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);

      applyReset("r-seq", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
      applyStimulus("seq a", 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
      applyStimulus("seq b", 1'b0, 1'b1, 2'b11, 1'b1, 1'b1);
      applyStimulus("seq ab", 1'b1, 1'b1, 2'b11, 1'b1, 1'b0);
      applyStimulus("seq none", 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);

      applyReset("r-end", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
      applyStimulus("idle stay", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

      @(negedge clk);
      assertCount++;
      if (expQueue.size() != 0) begin
         failCount++;
         $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", expQueue.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
